// File: rtl/osd_overlay_mixer.sv
// osd_overlay_mixer: raster counters for the icon ROM stage, ROM-latency delay line
// and a keyed / 50% alpha-blended icon mix into the top-left corner of the video.
`default_nettype none

module osd_overlay_mixer #(
  parameter int          ICON_W    = 50,
  parameter int          ICON_H    = 50,
  parameter int          ROM_LAT   = 3,
  parameter logic [23:0] KEY_COLOR = 24'h0,
  parameter logic        VS_POL    = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        vs_i,
  input  logic        hs_i,
  input  logic        de_i,
  input  logic [23:0] rgb_i,
  input  logic        blend_en,
  output logic [11:0] pixel_x,
  output logic [11:0] pixel_y,
  output logic        de_o_rom,
  input  logic [23:0] font_data,
  input  logic [2:0]  color_select,
  output logic        vs_o,
  output logic        hs_o,
  output logic        de_o,
  output logic [23:0] rgb_o
);

  localparam int          c_DL_W  = 28;
  localparam logic [12:0] c_WIN_W = 13'(ICON_W);
  localparam logic [12:0] c_WIN_H = 13'(ICON_H);
  localparam logic [c_DL_W-1:0] c_DL_RST = {~VS_POL, 3'b000, 24'h0};

  // S0 registers and their one-cycle-old copies for edge detection
  logic        r_vs0;
  logic        r_hs0;
  logic        r_de0;
  logic [23:0] r_rgb0;
  logic        r_vs_q;
  logic        r_de_q;

  logic [11:0] r_px;
  logic [11:0] r_py;
  logic        r_frame_ok;

  logic        w_vs_edge;
  logic        w_de_fall;
  logic        w_win;
  logic [11:0] w_px_inc;
  logic [11:0] w_py_inc;

  logic [c_DL_W-1:0] r_dl [ROM_LAT];
  logic [c_DL_W-1:0] w_s0;
  logic [c_DL_W-1:0] w_tail;

  logic        w_tl_vs;
  logic        w_tl_hs;
  logic        w_tl_de;
  logic        w_tl_win;
  logic [23:0] w_tl_rgb;
  logic [23:0] w_blend;
  logic        w_ovl;
  logic [23:0] w_mix;

  logic        r_vs_o;
  logic        r_hs_o;
  logic        r_de_o;
  logic [23:0] r_rgb_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vs0  <= ~VS_POL;
      r_hs0  <= 1'b0;
      r_de0  <= 1'b0;
      r_rgb0 <= 24'h0;
      r_vs_q <= ~VS_POL;
      r_de_q <= 1'b0;
    end else begin
      r_vs0  <= vs_i;
      r_hs0  <= hs_i;
      r_de0  <= de_i;
      r_rgb0 <= rgb_i;
      r_vs_q <= r_vs0;
      r_de_q <= r_de0;
    end
  end

  assign w_vs_edge = (r_vs0 == VS_POL) && (r_vs_q != VS_POL);
  assign w_de_fall = r_de_q && !r_de0;
  assign w_px_inc  = (r_px == 12'hFFF) ? r_px : r_px + 12'd1;
  assign w_py_inc  = (r_py == 12'hFFF) ? r_py : r_py + 12'd1;

  // A frame start overrides a line end landing on the same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_px       <= 12'h0;
      r_py       <= 12'h0;
      r_frame_ok <= 1'b0;
    end else if (w_vs_edge) begin
      r_px       <= 12'h0;
      r_py       <= 12'h0;
      r_frame_ok <= 1'b1;
    end else begin
      r_px <= r_de0 ? w_px_inc : 12'h0;
      if (w_de_fall) begin
        r_py <= w_py_inc;
      end
    end
  end

  assign w_win = r_de0 && ({1'b0, r_px} < c_WIN_W) && ({1'b0, r_py} < c_WIN_H);
  assign w_s0  = {r_vs0, r_hs0, r_de0, w_win, r_rgb0};

  genvar gi;
  generate
    for (gi = 0; gi < ROM_LAT; gi++) begin : g_dl
      if (gi == 0) begin : g_head
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            r_dl[gi] <= c_DL_RST;
          end else begin
            r_dl[gi] <= w_s0;
          end
        end
      end else begin : g_tail
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            r_dl[gi] <= c_DL_RST;
          end else begin
            r_dl[gi] <= r_dl[gi-1];
          end
        end
      end
    end
  endgenerate

  assign w_tail   = r_dl[ROM_LAT-1];
  assign w_tl_vs  = w_tail[27];
  assign w_tl_hs  = w_tail[26];
  assign w_tl_de  = w_tail[25];
  assign w_tl_win = w_tail[24];
  assign w_tl_rgb = w_tail[23:0];

  // 9-bit channel sum cannot exceed 511, so bits [8:1] never overflow
  genvar gc;
  generate
    for (gc = 0; gc < 3; gc++) begin : g_ch
      logic [8:0] w_sum;
      assign w_sum = {1'b0, w_tl_rgb[gc*8 +: 8]} + {1'b0, font_data[gc*8 +: 8]} + 9'd1;
      assign w_blend[gc*8 +: 8] = w_sum[8:1];
    end
  endgenerate

  assign w_ovl = w_tl_win && (color_select != 3'd0) && (font_data != KEY_COLOR) && r_frame_ok;

  always_comb begin
    w_mix = w_tl_rgb;
    if (!w_tl_de || !r_frame_ok) begin
      w_mix = 24'h0;
    end else if (w_ovl) begin
      w_mix = blend_en ? w_blend : font_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vs_o  <= ~VS_POL;
      r_hs_o  <= 1'b0;
      r_de_o  <= 1'b0;
      r_rgb_o <= 24'h0;
    end else begin
      r_vs_o  <= w_tl_vs;
      r_hs_o  <= w_tl_hs;
      r_de_o  <= w_tl_de && r_frame_ok;
      r_rgb_o <= w_mix;
    end
  end

  assign pixel_x  = r_px;
  assign pixel_y  = r_py;
  assign de_o_rom = r_de0;
  assign vs_o     = r_vs_o;
  assign hs_o     = r_hs_o;
  assign de_o     = r_de_o;
  assign rgb_o    = r_rgb_o;

endmodule

`default_nettype wire

// File: tb/tb_osd_overlay_mixer.sv
// tb_osd_overlay_mixer: directed frames against a pixel-level reference model of the mixer.
`default_nettype none

module tb_osd_overlay_mixer;

  localparam int N   = 32768;
  localparam int LAT = 4;   // posedge index distance from input sample to output register
  localparam int FW  = 60;
  localparam int FH  = 56;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        vs_i = 1'b0, hs_i = 1'b0, de_i = 1'b0, blend_en = 1'b0;
  logic [23:0] rgb_i = 24'h0, font_data = 24'h0;
  logic [2:0]  color_select = 3'd0;
  logic [11:0] pixel_x, pixel_y;
  logic        de_o_rom, vs_o, hs_o, de_o;
  logic [23:0] rgb_o;

  osd_overlay_mixer dut (
    .clk(clk), .rst_n(rst_n), .vs_i(vs_i), .hs_i(hs_i), .de_i(de_i), .rgb_i(rgb_i),
    .blend_en(blend_en), .pixel_x(pixel_x), .pixel_y(pixel_y), .de_o_rom(de_o_rom),
    .font_data(font_data), .color_select(color_select),
    .vs_o(vs_o), .hs_o(hs_o), .de_o(de_o), .rgb_o(rgb_o)
  );

  always #5 clk = ~clk;

  logic        a_vs[N], a_hs[N], a_de[N], a_rst[N], a_win[N], a_ok[N], a_bl[N];
  logic [23:0] a_rgb[N], a_fd[N], obs_rgb[N];
  logic [2:0]  a_cs[N];
  int          a_x[N], a_y[N], a_gx[N], a_gy[N], a_pat[N], obs_px[N], obs_py[N];
  int          idx_of[64][64];

  int   n = 0, checks = 0, failures = 0, deo_cnt = 0;
  int   m_run = 0, m_y = 0;
  logic m_pvs = 1'b0, m_pde = 1'b0, m_ok = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (sample %0d)", nm, act, exp, n);
    end
  endtask

  function automatic logic [23:0] rgbf(input int pat, input int x, input int y);
    logic [7:0] r, g, b;
    if (pat == 2) return 24'h7F0002;
    r = 8'(x * 3);
    g = 8'(y * 5);
    b = 8'(x ^ y);
    return {r, g, b};
  endfunction

  // Icon ROM behaviour per pattern, as seen for a given raster position
  task automatic romf(input int pat, input int x, input int y,
                      output logic [23:0] fd, output logic [2:0] cs, output logic bl);
    fd = 24'h123456; cs = 3'd0; bl = 1'b0;
    case (pat)
      1: begin fd = 24'hFF0000; cs = 3'd1; end
      2: begin fd = (y < 25) ? 24'h000000 : 24'h80FF01; cs = 3'd1; bl = 1'b1; end
      3: begin
        fd = 24'h204060;
        cs = (x < 10) ? 3'd1 : (x < 20) ? 3'd2 : (x < 30) ? 3'd0 : 3'd1;
        bl = (x >= 35);
      end
      default: ;
    endcase
  endtask

  function automatic logic [23:0] avg(input logic [23:0] a, input logic [23:0] b);
    logic [23:0] res;
    for (int c = 0; c < 3; c++) res[c*8 +: 8] = 8'((int'(a[c*8 +: 8]) + int'(b[c*8 +: 8]) + 1) / 2);
    return res;
  endfunction

  task automatic compare(input int k);
    int m;
    logic anyrst, evs, ehs, ede, ovl;
    logic [23:0] erg;
    if (a_rst[k]) begin
      chk("rom_de_reset", 32'(de_o_rom), 32'd0);
      chk("pixel_x_reset", 32'(pixel_x), 32'd0);
      chk("pixel_y_reset", 32'(pixel_y), 32'd0);
    end else begin
      chk("de_o_rom", 32'(de_o_rom), 32'(a_de[k]));
      if (a_de[k]) begin
        chk("pixel_x", 32'(pixel_x), 32'(a_x[k]));
        chk("pixel_y", 32'(pixel_y), 32'(a_y[k]));
      end
    end
    obs_px[k] = int'(pixel_x);
    obs_py[k] = int'(pixel_y);
    if (de_o) deo_cnt++;
    m = k - LAT;
    if (m < 0) return;
    anyrst = 1'b0;
    for (int j = m; j <= k; j++) anyrst |= a_rst[j];
    if (anyrst) begin
      evs = 1'b0; ehs = 1'b0; ede = 1'b0; erg = 24'h0;
    end else begin
      evs = a_vs[m];
      ehs = a_hs[m];
      ede = a_de[m] && a_ok[m];
      ovl = a_win[m] && (a_cs[k] != 3'd0) && (a_fd[k] != 24'h0);
      if (!ede)        erg = 24'h0;
      else if (!ovl)   erg = a_rgb[m];
      else if (a_bl[k]) erg = avg(a_rgb[m], a_fd[k]);
      else             erg = a_fd[k];
    end
    chk("vs_o", 32'(vs_o), 32'(evs));
    chk("hs_o", 32'(hs_o), 32'(ehs));
    chk("de_o", 32'(de_o), 32'(ede));
    chk("rgb_o", 32'(rgb_o), 32'(erg));
    obs_rgb[m] = rgb_o;
  endtask

  task automatic step(input logic v, input logic h, input logic d, input int pat, input int gx, input int gy);
    logic [23:0] fd;
    logic [2:0]  cs;
    logic        bl;
    if (n >= LAT && a_de[n-LAT]) romf(a_pat[n-LAT], a_gx[n-LAT], a_gy[n-LAT], fd, cs, bl);
    else begin fd = 24'hABCDEF; cs = 3'd3; bl = 1'(n & 1); end
    vs_i = v; hs_i = h; de_i = d;
    rgb_i = d ? rgbf(pat, gx, gy) : 24'h5A5A5A;
    font_data = fd; color_select = cs; blend_en = bl;
    a_vs[n] = v; a_hs[n] = h; a_de[n] = d; a_rgb[n] = rgb_i; a_fd[n] = fd; a_cs[n] = cs;
    a_bl[n] = bl; a_pat[n] = pat; a_gx[n] = gx; a_gy[n] = gy; a_rst[n] = !rst_n;
    a_x[n] = 0; a_win[n] = 1'b0;
    if (!rst_n) begin
      m_run = 0; m_y = 0; m_pvs = 1'b0; m_pde = 1'b0; m_ok = 1'b0;
    end else begin
      if (v && !m_pvs) begin m_y = 0; m_ok = 1'b1; end
      else if (m_pde && !d && m_y < 4095) m_y++;
      if (d) begin a_x[n] = m_run; if (m_run < 4095) m_run++; end
      else m_run = 0;
      a_win[n] = d && a_x[n] < 50 && m_y < 50;
      m_pvs = v; m_pde = d;
    end
    a_y[n] = m_y;
    a_ok[n] = m_ok;
    @(posedge clk);
    #1;
    compare(n);
    n++;
  endtask

  task automatic idle(input int c);
    for (int i = 0; i < c; i++) step(1'b0, 1'b0, 1'b0, 0, 0, 0);
  endtask

  task automatic frame(input int pat, input int w, input int h, input bit coincide_end);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, pat, 0, 0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, pat, 0, 0);
    for (int y = 0; y < h; y++) begin
      for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, pat, 0, 0);
      for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, pat, 0, 0);
      for (int x = 0; x < w; x++) begin
        idx_of[x][y] = n;
        step(1'b0, 1'b0, 1'b1, pat, x, y);
      end
      if (!(coincide_end && y == h - 1)) begin
        step(1'b0, 1'b0, 1'b0, pat, 0, 0);
        step(1'b0, 1'b0, 1'b0, pat, 0, 0);
      end
    end
  endtask

  initial begin
    int i9, i29, i30, i35;
    // Reset, then a line of icon-window pixels that must stay blank before any vs
    idle(4);
    rst_n = 1'b1;
    idle(3);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b1, 1, i, 0);
    rst_n = 1'b0;
    #1;
    chk("t1_async_rgb", 32'(rgb_o), 32'd0);
    chk("t1_async_vs", 32'(vs_o), 32'd0);
    chk("t1_async_de_rom", 32'(de_o_rom), 32'd0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1, 20 + i, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b1, 1, i, 0);
    idle(10);
    chk("t1_no_de_before_vs", 32'(deo_cnt), 32'd0);

    frame(0, FW, FH, 1'b0);
    idle(8);
    chk("t2_px_last", 32'(obs_px[idx_of[59][55]]), 32'd59);
    chk("t2_py_last", 32'(obs_py[idx_of[59][55]]), 32'd55);
    chk("t2_rgb_last", 32'(obs_rgb[idx_of[59][55]]), 32'hB1130C);

    frame(1, FW, FH, 1'b0);
    idle(8);
    chk("t3_corner00", 32'(obs_rgb[idx_of[0][0]]), 32'hFF0000);
    chk("t3_corner4949", 32'(obs_rgb[idx_of[49][49]]), 32'hFF0000);
    chk("t3_x50", 32'(obs_rgb[idx_of[50][0]]), 32'h960032);
    chk("t3_y50", 32'(obs_rgb[idx_of[0][50]]), 32'h00FA32);
    chk("t3_x50y49", 32'(obs_rgb[idx_of[50][49]]), 32'h96F503);
    chk("t3_x49y50", 32'(obs_rgb[idx_of[49][50]]), 32'h93FA03);

    frame(2, FW, FH, 1'b0);
    idle(8);
    chk("t4_key", 32'(obs_rgb[idx_of[10][10]]), 32'h7F0002);
    chk("t4_blend", 32'(obs_rgb[idx_of[10][30]]), 32'h808002);
    chk("t4_outside", 32'(obs_rgb[idx_of[55][30]]), 32'h7F0002);

    frame(3, FW, FH, 1'b1);
    i9 = idx_of[9][5]; i29 = idx_of[29][5]; i30 = idx_of[30][5]; i35 = idx_of[35][5];
    frame(0, FW, 3, 1'b0);
    idle(8);
    chk("t6_cs1", 32'(obs_rgb[i9]), 32'h204060);
    chk("t6_cs0", 32'(obs_rgb[i29]), 32'h571918);
    chk("t6_cs_back", 32'(obs_rgb[i30]), 32'h204060);
    chk("t6_blend_on", 32'(obs_rgb[i35]), 32'h452D43);
    chk("t5_coincide_y0", 32'(obs_py[idx_of[0][0]]), 32'd0);
    chk("t5_coincide_y1", 32'(obs_py[idx_of[5][1]]), 32'd1);
    chk("t5_coincide_y2", 32'(obs_py[idx_of[0][2]]), 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
